hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 18 +
 rtl/hazard_ctrl_fwd_sel.sv | 25 ++
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// EX operand forward-select codes and the write-back source code for loads.
package hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN = 2'b00,
      ST_LDW = 2'b01,
      ST_MDU = 2'b10,
      ST_MEM = 2'b11
   } hz_state_e;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   localparam logic [1:0] WB_SEL_LOAD = 2'b11;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding comparator for one EX source operand; MEM result wins over WB,
// and x0 is never forwarded.
module fwd_sel
   import hazard_ctrl_pkg::*;
#(
   parameter int AW = 5
) (
   input  logic [AW-1:0] rs_i,
   input  logic [AW-1:0] rd_m_i,
   input  logic          wb_en_m_i,
   input  logic [AW-1:0] rd_w_i,
   input  logic          wb_en_w_i,
   output logic [1:0]    sel_o
);

   always_comb begin
      sel_o = FWD_RF;
      if (wb_en_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
         sel_o = FWD_MEM;
      end else if (wb_en_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
         sel_o = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables/bubbles for load-use, MDU and
// data-memory stalls plus branch flush, EX operand forwarding, stall counter.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int AW         = 5,
   parameter int LOAD_STALL = 1,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       wb_sel_e,
   input  logic [AW-1:0]    rd_e,
   input  logic [AW-1:0]    rd_m,
   input  logic             wb_en_m,
   input  logic [AW-1:0]    rd_w,
   input  logic             wb_en_w,
   input  logic [AW-1:0]    rs1_d,
   input  logic [AW-1:0]    rs2_d,
   input  logic             rs1_need,
   input  logic             rs2_need,
   input  logic [AW-1:0]    rs1_e,
   input  logic [AW-1:0]    rs2_e,
   input  logic             taken,
   input  logic             mdu_start,
   input  logic             mdu_done,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             if_en,
   output logic             de_en,
   output logic             ex_en,
   output logic             de_rst,
   output logic             ex_rst,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [1:0] LDW_INIT = 2'(LOAD_STALL - 1);

   hz_state_e        state_q, state_d, cur_st;
   logic [1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic             hazard_ld, mem_wait, mdu_wait, run_dec;

   assign hazard_ld = (wb_sel_e == WB_SEL_LOAD) && (rd_e != '0) &&
                      (((rd_e == rs1_d) && rs1_need) || ((rd_e == rs2_d) && rs2_need));
   assign mem_wait  = dmem_req && !dmem_ready;
   assign mdu_wait  = mdu_start && !mdu_done;

   // While rst is high the outputs decode as RUN so an in-flight freeze is not visible
   assign cur_st = rst ? ST_RUN : state_q;

   always_comb begin
      state_d = cur_st;
      cnt_d   = cnt_q;
      if_en   = 1'b1;
      de_en   = 1'b1;
      ex_en   = 1'b1;
      de_rst  = 1'b0;
      ex_rst  = 1'b0;
      run_dec = 1'b0;
      unique case (cur_st)
         ST_RUN: run_dec = 1'b1;
         ST_LDW: begin
            if (taken) begin
               de_rst  = 1'b1;
               ex_rst  = 1'b1;
               state_d = ST_RUN;
            end else begin
               if_en  = 1'b0;
               de_en  = 1'b0;
               ex_rst = 1'b1;
               cnt_d  = cnt_q - 2'd1;
               if (cnt_q == 2'd1) state_d = ST_RUN;
            end
         end
         ST_MDU: begin
            if (mdu_done) begin
               run_dec = 1'b1;
            end else begin
               if_en = 1'b0;
               de_en = 1'b0;
               ex_en = 1'b0;
            end
         end
         ST_MEM: begin
            if (dmem_ready) begin
               run_dec = 1'b1;
            end else begin
               if_en = 1'b0;
               de_en = 1'b0;
               ex_en = 1'b0;
            end
         end
      endcase

      // Exit cycles of MDU/MEM share the RUN decode, so a pending taken is acted on here
      if (run_dec) begin
         state_d = ST_RUN;
         if (mem_wait) begin
            if_en   = 1'b0;
            de_en   = 1'b0;
            ex_en   = 1'b0;
            state_d = ST_MEM;
         end else if (mdu_wait) begin
            if_en   = 1'b0;
            de_en   = 1'b0;
            ex_en   = 1'b0;
            state_d = ST_MDU;
         end else if (taken) begin
            de_rst = 1'b1;
            ex_rst = 1'b1;
         end else if (hazard_ld) begin
            if_en  = 1'b0;
            de_en  = 1'b0;
            ex_rst = 1'b1;
            if (LOAD_STALL > 1) begin
               cnt_d   = LDW_INIT;
               state_d = ST_LDW;
            end
         end
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (!if_en && (stall_q != '1)) stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         cnt_q   <= 2'd0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
      end
   end

   assign stall_cycles = stall_q;

   fwd_sel #(.AW(AW)) u_fwd_a (
      .rs_i      (rs1_e),
      .rd_m_i    (rd_m),
      .wb_en_m_i (wb_en_m),
      .rd_w_i    (rd_w),
      .wb_en_w_i (wb_en_w),
      .sel_o     (fwd_a)
   );

   fwd_sel #(.AW(AW)) u_fwd_b (
      .rs_i      (rs2_e),
      .rd_m_i    (rd_m),
      .wb_en_m_i (wb_en_m),
      .rd_w_i    (rd_w),
      .wb_en_w_i (wb_en_w),
      .sel_o     (fwd_b)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with LOAD_STALL=1, one with
// LOAD_STALL=3 and a 2-bit stall counter, both driven by the same inputs.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] wb_sel_e;
   logic [4:0] rd_e, rd_m, rd_w, rs1_d, rs2_d, rs1_e, rs2_e;
   logic       wb_en_m, wb_en_w, rs1_need, rs2_need;
   logic       taken, mdu_start, mdu_done, dmem_req, dmem_ready;

   logic        if_en1, de_en1, ex_en1, de_rst1, ex_rst1;
   logic [1:0]  fwd_a1, fwd_b1;
   logic [31:0] stall1;
   logic        if_en3, de_en3, ex_en3, de_rst3, ex_rst3;
   logic [1:0]  fwd_a3, fwd_b3;
   logic [1:0]  stall3;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.AW(5), .LOAD_STALL(1), .CNT_W(32)) u_dut1 (
      .clk(clk), .rst(rst), .wb_sel_e(wb_sel_e), .rd_e(rd_e), .rd_m(rd_m),
      .wb_en_m(wb_en_m), .rd_w(rd_w), .wb_en_w(wb_en_w), .rs1_d(rs1_d),
      .rs2_d(rs2_d), .rs1_need(rs1_need), .rs2_need(rs2_need), .rs1_e(rs1_e),
      .rs2_e(rs2_e), .taken(taken), .mdu_start(mdu_start), .mdu_done(mdu_done),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .if_en(if_en1), .de_en(de_en1),
      .ex_en(ex_en1), .de_rst(de_rst1), .ex_rst(ex_rst1), .fwd_a(fwd_a1),
      .fwd_b(fwd_b1), .stall_cycles(stall1)
   );

   hazard_ctrl #(.AW(5), .LOAD_STALL(3), .CNT_W(2)) u_dut3 (
      .clk(clk), .rst(rst), .wb_sel_e(wb_sel_e), .rd_e(rd_e), .rd_m(rd_m),
      .wb_en_m(wb_en_m), .rd_w(rd_w), .wb_en_w(wb_en_w), .rs1_d(rs1_d),
      .rs2_d(rs2_d), .rs1_need(rs1_need), .rs2_need(rs2_need), .rs1_e(rs1_e),
      .rs2_e(rs2_e), .taken(taken), .mdu_start(mdu_start), .mdu_done(mdu_done),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .if_en(if_en3), .de_en(de_en3),
      .ex_en(ex_en3), .de_rst(de_rst3), .ex_rst(ex_rst3), .fwd_a(fwd_a3),
      .fwd_b(fwd_b3), .stall_cycles(stall3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Enables packed as {if_en, de_en, ex_en, de_rst, ex_rst}
   function automatic logic [31:0] ctl1();
      return {27'd0, if_en1, de_en1, ex_en1, de_rst1, ex_rst1};
   endfunction
   function automatic logic [31:0] ctl3();
      return {27'd0, if_en3, de_en3, ex_en3, de_rst3, ex_rst3};
   endfunction

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic clear_in();
      wb_sel_e = 2'b00; rd_e = '0; rd_m = '0; rd_w = '0; rs1_d = '0; rs2_d = '0;
      rs1_e = '0; rs2_e = '0; wb_en_m = 0; wb_en_w = 0; rs1_need = 0; rs2_need = 0;
      taken = 0; mdu_start = 0; mdu_done = 0; dmem_req = 0; dmem_ready = 0;
   endtask

   initial begin
      clear_in();
      rst = 1'b1;
      adv();
      adv();
      settle();
      chk("rst_ctl1", ctl1(), 32'b11100);
      chk("rst_ctl3", ctl3(), 32'b11100);
      chk("rst_fwd", {28'd0, fwd_a1, fwd_b1}, 32'd0);
      chk("rst_stall1", stall1, 32'd0);
      chk("rst_stall3", {30'd0, stall3}, 32'd0);
      adv();
      rst = 1'b0;
      adv();

      // load x5 in EX, DE reads x5
      wb_sel_e = 2'b11; rd_e = 5'd5; rs1_d = 5'd5; rs1_need = 1;
      settle();
      chk("ld_ctl1", ctl1(), 32'b00101);
      chk("ld_ctl3", ctl3(), 32'b00101);
      adv();
      wb_sel_e = 2'b00; rd_e = '0;
      settle();
      chk("ld1_done", ctl1(), 32'b11100);
      chk("ld1_stall", stall1, 32'd1);
      chk("ld3_b2", ctl3(), 32'b00101);
      adv();
      settle();
      chk("ld3_b3", ctl3(), 32'b00101);
      adv();
      settle();
      chk("ld3_done", ctl3(), 32'b11100);
      chk("ld3_stall", {30'd0, stall3}, 32'd3);

      // load into x0 never stalls; rs2 match without rs2_need never stalls
      wb_sel_e = 2'b11; rd_e = 5'd0; rs1_d = 5'd0; rs1_need = 1;
      settle();
      chk("ld_x0", ctl3(), 32'b11100);
      adv();
      rd_e = 5'd9; rs1_d = 5'd1; rs2_d = 5'd9; rs2_need = 0;
      settle();
      chk("ld_noneed", ctl3(), 32'b11100);
      adv();

      // load-use together with taken: flush wins, no LDW
      clear_in();
      wb_sel_e = 2'b11; rd_e = 5'd5; rs1_d = 5'd5; rs1_need = 1; taken = 1;
      settle();
      chk("ldtk_ctl1", ctl1(), 32'b11111);
      chk("ldtk_ctl3", ctl3(), 32'b11111);
      adv();
      clear_in();
      settle();
      chk("ldtk_noldw", ctl3(), 32'b11100);
      chk("ldtk_stall1", stall1, 32'd1);
      adv();

      // memory wait 4 cycles, taken raised during the wait
      dmem_req = 1; dmem_ready = 0;
      for (int i = 0; i < 4; i++) begin
         taken = (i >= 2);
         settle();
         chk($sformatf("memw_ctl1_%0d", i), ctl1(), 32'b00000);
         chk($sformatf("memw_ctl3_%0d", i), ctl3(), 32'b00000);
         adv();
      end
      dmem_ready = 1; taken = 1;
      settle();
      chk("mem_exit_flush", ctl1(), 32'b11111);
      adv();
      clear_in();
      settle();
      chk("mem_after", ctl1(), 32'b11100);
      chk("mem_stall1", stall1, 32'd5);
      chk("mem_stall3_sat", {30'd0, stall3}, 32'd3);

      // forwarding
      rd_m = 5'd7; rd_w = 5'd7; wb_en_m = 1; wb_en_w = 1; rs1_e = 5'd7; rs2_e = 5'd3;
      settle();
      chk("fwd_a_mem", {30'd0, fwd_a1}, 32'd1);
      chk("fwd_b_none", {30'd0, fwd_b1}, 32'd0);
      wb_en_m = 0; rs2_e = 5'd7;
      #2;
      chk("fwd_a_wb", {30'd0, fwd_a1}, 32'd2);
      chk("fwd_b_wb", {30'd0, fwd_b3}, 32'd2);
      rs1_e = 5'd0; rd_w = 5'd0; rs2_e = 5'd0;
      #2;
      chk("fwd_a_x0", {30'd0, fwd_a1}, 32'd0);
      chk("fwd_b_x0", {30'd0, fwd_b1}, 32'd0);
      adv();
      clear_in();

      // MDU exit on done
      mdu_start = 1;
      settle();
      chk("mdu_freeze", ctl1(), 32'b00000);
      adv();
      mdu_done = 1;
      settle();
      chk("mdu_exit", ctl1(), 32'b11100);
      adv();
      clear_in();
      settle();
      chk("mdu_stall1", stall1, 32'd6);

      // reset while frozen in MDU
      mdu_start = 1;
      adv();
      settle();
      chk("mdu_busy", ctl1(), 32'b00000);
      chk("mdu_busy_stall1", stall1, 32'd7);
      adv();
      rst = 1;
      mdu_start = 0;
      adv();
      rst = 0;
      settle();
      chk("rstmdu_ctl1", ctl1(), 32'b11100);
      chk("rstmdu_ctl3", ctl3(), 32'b11100);
      chk("rstmdu_stall1", stall1, 32'd0);
      chk("rstmdu_stall3", {30'd0, stall3}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
